// File: rtl/aes_output_buffer.sv
// Buffers 128-bit AES results in a small block FIFO and streams each block as 4 x 32-bit words.
// Define AES_OUTBUF_MSW_FIRST_EN to send text[127:96] first instead of text[31:0].
module aes_output_buffer #(
    parameter int DEPTH = 2,
    parameter int AW    = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          done_i,
    input  logic [127:0]  text_i,
    output logic          full_o,
    output logic [31:0]   dout_o,
    output logic          dout_valid_o,
    input  logic          dout_ready_i,
    output logic          dout_last_o,
    output logic          overflow_o,
    input  logic          clr_ovf_i,
    output logic [AW:0]   count_o
);
    typedef enum logic {IDLE, SEND} state_e;

    state_e         state_q, state_d;
    logic [AW:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, count_q, count_d;
    logic           full_q, full_d, ovf_q, ovf_d;
    logic [127:0]   mem_q [DEPTH];
    logic [127:0]   shift_q, shift_d, shift_adv;
    logic [1:0]     cnt_q, cnt_d;
    logic [31:0]    word;
    logic           empty, full_ptr, hs, pop, push;

    assign empty    = (wr_ptr_q == rd_ptr_q);
    assign full_ptr = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign hs       = (state_q == SEND) && dout_ready_i;

`ifdef AES_OUTBUF_MSW_FIRST_EN
    assign word      = shift_q[127:96];
    assign shift_adv = {shift_q[95:0], 32'h0};
`else
    assign word      = shift_q[31:0];
    assign shift_adv = {32'h0, shift_q[127:32]};
`endif

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    shift_d = mem_q[rd_ptr_q[AW-1:0]];
                    cnt_d   = 2'd0;
                    state_d = SEND;
                end
            end
            default: begin
                if (hs) begin
                    if (cnt_q != 2'd3) begin
                        cnt_d   = cnt_q + 2'd1;
                        shift_d = shift_adv;
                    end else if (!empty) begin
                        // chain straight into the next block so the host sees no bubble
                        pop     = 1'b1;
                        shift_d = mem_q[rd_ptr_q[AW-1:0]];
                        cnt_d   = 2'd0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
        endcase
        // a pop on this edge frees the slot a full FIFO would otherwise refuse
        push     = done_i && (!full_ptr || pop);
        wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, push};
        rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop};
        count_d  = wr_ptr_d - rd_ptr_d;
        full_d   = (count_d == (AW+1)'(DEPTH));
        ovf_d    = ovf_q;
        if (done_i && !push) ovf_d = 1'b1;
        else if (clr_ovf_i)  ovf_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            ovf_q    <= 1'b0;
            shift_q  <= '0;
            cnt_q    <= 2'd0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            ovf_q    <= ovf_d;
            shift_q  <= shift_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst && push) mem_q[wr_ptr_q[AW-1:0]] <= text_i;
    end

    assign dout_valid_o = (state_q == SEND);
    assign dout_o       = dout_valid_o ? word : 32'h0;
    assign dout_last_o  = dout_valid_o && (cnt_q == 2'd3);
    assign full_o       = full_q;
    assign count_o      = count_q;
    assign overflow_o   = ovf_q;
endmodule

// File: tb/tb_aes_output_buffer.sv
// Directed plus random stimulus for aes_output_buffer, checked each cycle against a block-queue model.
module tb_aes_output_buffer;
    localparam int DEPTH = 2;
    localparam int AW    = 1;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          done_i = 1'b0;
    logic [127:0]  text_i = '0;
    logic          full_o;
    logic [31:0]   dout_o;
    logic          dout_valid_o;
    logic          dout_ready_i = 1'b0;
    logic          dout_last_o;
    logic          overflow_o;
    logic          clr_ovf_i = 1'b0;
    logic [AW:0]   count_o;

    aes_output_buffer #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk), .rst(rst), .done_i(done_i), .text_i(text_i), .full_o(full_o),
        .dout_o(dout_o), .dout_valid_o(dout_valid_o), .dout_ready_i(dout_ready_i),
        .dout_last_o(dout_last_o), .overflow_o(overflow_o), .clr_ovf_i(clr_ovf_i),
        .count_o(count_o)
    );

    always #5 clk = ~clk;

    int errs = 0;
    int checks = 0;

    // reference: blocks waiting in FIFO, block being sent and words still owed
    logic [127:0] blk_q[$];
    logic [127:0] cur = '0;
    int           left = 0;
    bit           ovf = 1'b0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] exp_word();
        int idx;
        idx = 4 - left;
`ifdef AES_OUTBUF_MSW_FIRST_EN
        return cur[32*(3-idx) +: 32];
`else
        return cur[32*idx +: 32];
`endif
    endfunction

    task automatic model_step();
        bit hs, pop, push;
        if (!rst) begin
            blk_q.delete();
            left = 0;
            ovf  = 1'b0;
            return;
        end
        hs   = (left > 0) && dout_ready_i;
        pop  = (blk_q.size() > 0) && ((left == 0) || (hs && left == 1));
        push = done_i && ((blk_q.size() < DEPTH) || pop);
        if (done_i && !push) ovf = 1'b1;
        else if (clr_ovf_i)  ovf = 1'b0;
        if (hs) left--;
        if (pop) begin
            cur  = blk_q.pop_front();
            left = 4;
        end
        if (push) blk_q.push_back(text_i);
    endtask

    task automatic check_outputs();
        chk("valid", dout_valid_o, left > 0);
        chk("dout", dout_o, (left > 0) ? exp_word() : 32'h0);
        chk("last", dout_last_o, left == 1);
        chk("count", count_o, blk_q.size());
        chk("full", full_o, blk_q.size() == DEPTH);
        chk("ovf", overflow_o, ovf);
    endtask

    task automatic cyc(input bit d, input logic [127:0] t, input bit r, input bit c, input bit rs);
        done_i = d; text_i = t; dout_ready_i = r; clr_ovf_i = c; rst = rs;
        model_step();
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    function automatic logic [127:0] rnd_blk();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    logic [127:0] blk2;
    int n;

    initial begin
        blk2 = 128'h33333333_22222222_11111111_00000000;

        // reset held with done_i asserted
        for (int i = 0; i < 3; i++) cyc(1, rnd_blk(), 1, 0, 0);
        chk("rst_count", count_o, 0);
        chk("rst_valid", dout_valid_o, 0);
        cyc(0, '0, 1, 0, 1);

        // single block, host always ready
        cyc(1, blk2, 1, 0, 1);
        cyc(0, '0, 1, 0, 1);
`ifdef AES_OUTBUF_MSW_FIRST_EN
        chk("first_word", dout_o, 32'h33333333);
`else
        chk("first_word", dout_o, 32'h00000000);
`endif
        for (int i = 0; i < 5; i++) cyc(0, '0, 1, 0, 1);
        chk("idle_after", dout_valid_o, 0);

        // backpressure pattern 1,0,0,1,...
        cyc(1, rnd_blk(), 0, 0, 1);
        for (int i = 0; i < 14; i++) cyc(0, '0, (i % 3) == 0, 0, 1);
        for (int i = 0; i < 4; i++) cyc(0, '0, 1, 0, 1);

        // back-to-back blocks drained with ready high
        for (int i = 0; i < 3; i++) cyc(1, rnd_blk(), 1, 0, 1);
        for (int i = 0; i < 14; i++) cyc(0, '0, 1, 0, 1);

        // ready low: three blocks fit, fourth overflows
        for (int i = 0; i < 3; i++) cyc(1, rnd_blk(), 0, 0, 1);
        chk("full_after3", full_o, 1);
        chk("ovf_before4", overflow_o, 0);
        cyc(1, rnd_blk(), 0, 0, 1);
        chk("ovf_after4", overflow_o, 1);
        cyc(0, '0, 0, 1, 1);
        chk("ovf_cleared", overflow_o, 0);
        cyc(1, rnd_blk(), 0, 1, 1);
        chk("ovf_set_wins", overflow_o, 1);

        // reset after two words of a block, then a fresh block
        cyc(0, '0, 0, 0, 0);
        cyc(1, blk2, 1, 0, 1);
        cyc(0, '0, 1, 0, 1);
        cyc(0, '0, 1, 0, 1);
        cyc(0, '0, 1, 0, 0);
        chk("midrst_valid", dout_valid_o, 0);
        cyc(1, blk2, 1, 0, 1);
        cyc(0, '0, 1, 0, 1);
`ifdef AES_OUTBUF_MSW_FIRST_EN
        chk("restart_word0", dout_o, 32'h33333333);
`else
        chk("restart_word0", dout_o, 32'h00000000);
`endif

        // random traffic
        n = 0;
        while (n < 3000) begin
            cyc($urandom_range(0, 3) == 0, rnd_blk(), $urandom_range(0, 2) != 0,
                $urandom_range(0, 15) == 0, $urandom_range(0, 199) != 0);
            n++;
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
